// File: rtl/vga_timing_gen.sv
// VGA raster timing: position counters, registered sync/blanking decode and line/frame pulses.
// Define VGA_TIMING_LOOKAHEAD_EN to delay the decode one enabled cycle behind x/y.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned SYNC_POL = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pix_en,
    output logic       hsync,
    output logic       vsync,
    output logic       h_display,
    output logic       v_display,
    output logic       display_en,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       line_start,
    output logic       frame_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
    localparam logic [10:0] HS_BEG   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_BEG   = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic        SYNC_ACT = 1'(SYNC_POL);

    // Flag bit order: hsync, vsync, h_display, v_display, display_en, line_start, frame_start
    localparam logic [6:0] FLAGS_RST = {~SYNC_ACT, ~SYNC_ACT, 5'b0};

    logic [9:0] hc_q, hc_d;
    logic [9:0] vc_q, vc_d;
    logic [9:0] x_q, y_q;
    logic [6:0] flags_d, flags_q;
    logic [6:0] flags_out;

    always_comb begin
        logic [10:0] h;
        logic [10:0] v;
        logic        hd;
        logic        vd;

        hc_d = hc_q + 10'd1;
        vc_d = vc_q;
        if (hc_q == H_LAST) begin
            hc_d = '0;
            vc_d = (vc_q == V_LAST) ? '0 : vc_q + 10'd1;
        end

        h  = {1'b0, hc_q};
        v  = {1'b0, vc_q};
        hd = h < H_ACT;
        vd = v < V_ACT;

        flags_d    = '0;
        flags_d[6] = (h >= HS_BEG && h < HS_END) ? SYNC_ACT : ~SYNC_ACT;
        flags_d[5] = (v >= VS_BEG && v < VS_END) ? SYNC_ACT : ~SYNC_ACT;
        flags_d[4] = hd;
        flags_d[3] = vd;
        flags_d[2] = hd & vd;
        flags_d[1] = (hc_q == '0);
        flags_d[0] = (hc_q == '0) && (vc_q == '0);
    end

    // Outputs capture the decode of the pre-advance counters, so they lag hc/vc by one.
    always_ff @(posedge clk) begin
        if (reset) begin
            hc_q    <= '0;
            vc_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            flags_q <= FLAGS_RST;
        end else if (pix_en) begin
            hc_q    <= hc_d;
            vc_q    <= vc_d;
            x_q     <= hc_q;
            y_q     <= vc_q;
            flags_q <= flags_d;
        end
    end

`ifdef VGA_TIMING_LOOKAHEAD_EN
    // Extra stage so sync/enable line up with a 1-cycle-latency pixel source addressed by x/y.
    logic [6:0] flags_dly_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            flags_dly_q <= FLAGS_RST;
        end else if (pix_en) begin
            flags_dly_q <= flags_q;
        end
    end

    assign flags_out = flags_dly_q;
`else
    assign flags_out = flags_q;
`endif

    assign x           = x_q;
    assign y           = y_q;
    assign hsync       = flags_out[6];
    assign vsync       = flags_out[5];
    assign h_display   = flags_out[4];
    assign v_display   = flags_out[3];
    assign display_en  = flags_out[2];
    assign line_start  = flags_out[1];
    assign frame_start = flags_out[0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: a reduced-size raster for frame-level behaviour and the default 640x480
// raster for the line-level sync window.
module tb_vga_timing_gen;

    // Reduced raster: 15 pixels x 8 lines, hsync at 10..12, vsync at lines 5..6
    localparam int SHA = 8, SHF = 2, SHS = 3, SHB = 2;
    localparam int SVA = 4, SVF = 1, SVS = 2, SVB = 1;
    localparam int SHT = SHA + SHF + SHS + SHB;
    localparam int SVT = SVA + SVF + SVS + SVB;

`ifdef VGA_TIMING_LOOKAHEAD_EN
    localparam int LA = 1;
`else
    localparam int LA = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_s = 1'b1, en_s = 1'b0;
    logic       hs_s, vs_s, hd_s, vd_s, de_s, ls_s, fs_s;
    logic [9:0] x_s, y_s;
    logic [6:0] fl_s;

    logic       rst_d = 1'b1, en_d = 1'b0;
    logic       hs_d, vs_d, hd_d, vd_d, de_d, ls_d, fs_d;
    logic [9:0] x_d, y_d;
    logic [6:0] fl_d;

    vga_timing_gen #(
        .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
        .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB), .SYNC_POL(0)
    ) u_small (
        .clk(clk), .reset(rst_s), .pix_en(en_s),
        .hsync(hs_s), .vsync(vs_s), .h_display(hd_s), .v_display(vd_s),
        .display_en(de_s), .x(x_s), .y(y_s), .line_start(ls_s), .frame_start(fs_s)
    );

    vga_timing_gen u_dflt (
        .clk(clk), .reset(rst_d), .pix_en(en_d),
        .hsync(hs_d), .vsync(vs_d), .h_display(hd_d), .v_display(vd_d),
        .display_en(de_d), .x(x_d), .y(y_d), .line_start(ls_d), .frame_start(fs_d)
    );

    assign fl_s = {hs_s, vs_s, hd_s, vd_s, de_s, ls_s, fs_s};
    assign fl_d = {hs_d, vs_d, hd_d, vd_d, de_d, ls_d, fs_d};

    int n_chk  = 0;
    int n_fail = 0;
    int idx_s  = -1;  // enabled edges since reset release, minus one (position shown on x/y)
    int idx_d  = -1;

    // Expected {x, y, flags} for x/y position p and flag position pf (negative = reset value)
    function automatic logic [26:0] exp_vec(input int p, input int pf,
                                            input int ha, input int hf, input int hs,
                                            input int hb, input int va, input int vf,
                                            input int vs, input int vb);
        int ht, vt, h, v;
        logic [9:0] ex, ey;
        logic [6:0] f;
        ht = ha + hf + hs + hb;
        vt = va + vf + vs + vb;
        ex = '0;
        ey = '0;
        if (p >= 0) begin
            ex = 10'(p % ht);
            ey = 10'((p / ht) % vt);
        end
        f = 7'b1100000;
        if (pf >= 0) begin
            h    = pf % ht;
            v    = (pf / ht) % vt;
            f[6] = !(h >= ha + hf && h < ha + hf + hs);
            f[5] = !(v >= va + vf && v < va + vf + vs);
            f[4] = h < ha;
            f[3] = v < va;
            f[2] = (h < ha) && (v < va);
            f[1] = h == 0;
            f[0] = (h == 0) && (v == 0);
        end
        return {ex, ey, f};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_s) idx_s = -1; else if (en_s) idx_s++;
        if (rst_d) idx_d = -1; else if (en_d) idx_d++;
        #1;
    endtask

    task automatic chk_s(input string nm);
        check(nm, {5'b0, x_s, y_s, fl_s},
              {5'b0, exp_vec(idx_s, idx_s - LA, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB)});
    endtask

    task automatic chk_d(input string nm);
        check(nm, {5'b0, x_d, y_d, fl_d},
              {5'b0, exp_vec(idx_d, idx_d - LA, 640, 16, 96, 48, 480, 10, 2, 33)});
    endtask

    task automatic reset_s();
        rst_s = 1'b1;
        en_s  = 1'b1;
        tick();
        rst_s = 1'b0;
    endtask

    // Runs the small raster, checking every cycle plus line/frame periods and hold behaviour.
    task automatic run_s(input string nm, input int ncyc, input bit alt);
        int         last_ls, last_fs, de_cnt, n_fs;
        logic       p_ls, p_fs;
        logic [26:0] prev;
        last_ls = -1;
        last_fs = -1;
        de_cnt  = 0;
        n_fs    = 0;
        p_ls    = ls_s;
        p_fs    = fs_s;
        for (int i = 0; i < ncyc; i++) begin
            en_s = alt ? (i % 2 == 0) : 1'b1;
            prev = {x_s, y_s, fl_s};
            tick();
            chk_s({nm, "_model"});
            if (!en_s) check({nm, "_hold"}, {5'b0, x_s, y_s, fl_s}, {5'b0, prev});
            if (ls_s && !p_ls) begin
                if (last_ls >= 0) check({nm, "_line_period"}, i - last_ls, SHT * (alt ? 2 : 1));
                last_ls = i;
            end
            if (fs_s && !p_fs) begin
                if (last_fs >= 0) begin
                    check({nm, "_frame_period"}, i - last_fs, SHT * SVT * (alt ? 2 : 1));
                    check({nm, "_de_per_frame"}, de_cnt, SHA * SVA * (alt ? 2 : 1));
                    n_fs++;
                end
                last_fs = i;
                de_cnt  = 0;
            end
            if (last_fs >= 0 && de_s) de_cnt++;
            p_ls = ls_s;
            p_fs = fs_s;
        end
        check({nm, "_frames_seen"}, n_fs, 2);
    endtask

    typedef struct {
        logic       rst;
        logic       en;
        logic [9:0] x;
        logic [9:0] y;
        logic [6:0] fl;  // hsync, vsync, h_display, v_display, display_en, line_start, frame_start
    } vec_t;

    vec_t tbl[9];

    initial begin
        int   hs_low;
        bit   found;

        tbl[0] = '{1'b1, 1'b1, 10'd0, 10'd0, 7'b1100000};  // in reset
        tbl[1] = '{1'b1, 1'b0, 10'd0, 10'd0, 7'b1100000};  // reset ignores pix_en
        tbl[2] = '{1'b0, 1'b1, 10'd0, 10'd0, 7'b1111111};  // first enabled edge: (0,0)
        tbl[3] = '{1'b0, 1'b0, 10'd0, 10'd0, 7'b1111111};  // hold
        tbl[4] = '{1'b0, 1'b1, 10'd1, 10'd0, 7'b1111100};
        tbl[5] = '{1'b0, 1'b1, 10'd2, 10'd0, 7'b1111100};
        tbl[6] = '{1'b1, 1'b0, 10'd0, 10'd0, 7'b1100000};  // reset with pix_en low
        tbl[7] = '{1'b0, 1'b0, 10'd0, 10'd0, 7'b1100000};
        tbl[8] = '{1'b0, 1'b1, 10'd0, 10'd0, 7'b1111111};

        #1;
        for (int i = 0; i < 9; i++) begin
            rst_s = tbl[i].rst;
            en_s  = tbl[i].en;
            tick();
`ifndef VGA_TIMING_LOOKAHEAD_EN
            check($sformatf("vec%0d", i), {12'b0, x_s, y_s, fl_s},
                  {12'b0, tbl[i].x, tbl[i].y, tbl[i].fl});
`else
            check($sformatf("vec%0d_xy", i), {12'b0, x_s, y_s}, {12'b0, tbl[i].x, tbl[i].y});
`endif
            chk_s($sformatf("vec%0d_model", i));
        end

        // Two frames continuous, then alternating enable (periods double)
        reset_s();
        chk_s("rst_cont");
        run_s("cont", 2 * SHT * SVT + 20, 1'b0);
        reset_s();
        run_s("alt", 4 * SHT * SVT + 40, 1'b1);

        // Wrap from the last position of the frame
        reset_s();
        en_s  = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 3 * SHT * SVT && !found; i++) begin
            tick();
            found = (x_s == 10'(SHT - 1)) && (y_s == 10'(SVT - 1));
        end
        check("wrap_reached", {31'b0, found}, 32'd1);
        tick();
        check("wrap_xy", {12'b0, x_s, y_s}, 32'd0);
        chk_s("wrap_model");

        // Reset mid-line while hsync is active; pix_en low shows reset does not need it
        reset_s();
        en_s  = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 3 * SHT * SVT && !found; i++) begin
            tick();
            found = (x_s == 10'd11) && (y_s == 10'd2);
        end
        check("midrst_reached", {31'b0, found}, 32'd1);
        check("midrst_hs_active", {31'b0, hs_s}, 32'd0);
        rst_s = 1'b1;
        en_s  = 1'b0;
        tick();
        check("midrst_out", {12'b0, x_s, y_s, hs_s, de_s, fs_s}, {12'b0, 20'd0, 3'b100});
        rst_s = 1'b0;
        en_s  = 1'b1;
        tick();
        chk_s("midrst_first");
`ifndef VGA_TIMING_LOOKAHEAD_EN
        check("midrst_frame_start", {31'b0, fs_s}, 32'd1);
`endif

        // Default 640x480 raster: first two lines, hsync window 656..751
        en_d = 1'b1;
        tick();
        chk_d("dflt_rst");
        rst_d  = 1'b0;
        hs_low = 0;
        for (int i = 0; i < 1700; i++) begin
            tick();
            chk_d("dflt_model");
            if (i < 800 && !hs_d) hs_low++;
        end
        check("dflt_hsync_width", hs_low, 96);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
